// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - run/halt/single-step sequencer for the 3-stage 8-bit pipeline
//
// Drives the PC/fetch enable and the IF/ID, ID/EX and EX/WB load enables.
// Keeps one valid bit per pipeline register and inserts bubbles on jumps and drains.
// Qualifies register-file writeback so that bubbles never write, and counts retirements.
//
// Optional feature macro: SEQ_BKPT_EN (adds bkpt_hit / bkpt_flag)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   run_req       in   start / resume continuous execution
//   halt_req      in   stop fetching and drain
//   step_req      in   execute one instruction while halted
//   jump_taken    in   IF stage selected the jump target this cycle
//   bkpt_hit      in   breakpoint match, acts as halt in FILL/RUN   (SEQ_BKPT_EN only)
//   pc_en         out  PC update / fetch enable
//   ifid_en       out  IF/ID load enable
//   idex_en       out  ID/EX load enable
//   exwb_en       out  EX/WB load enable
//   ifid_flush    out  load a zero bubble into IF/ID
//   regwrite_gate out  AND-qualifier for EX/WB RegWrite
//   state         out  FSM state (IDLE=0 FILL=1 RUN=2 DRAIN=3 HALTED=4 STEP=5)
//   busy          out  any stage valid or fetch enabled
//   retired_cnt   out  retired instruction counter, wraps
//   bkpt_flag     out  sticky breakpoint indication            (SEQ_BKPT_EN only)

module pipeline_sequencer #(
    parameter int DEPTH     = 3,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             jump_taken,
`ifdef SEQ_BKPT_EN
    input  logic             bkpt_hit,
    output logic             bkpt_flag,
`endif
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exwb_en,
    output logic             ifid_flush,
    output logic             regwrite_gate,
    output logic [2:0]       state,
    output logic             busy,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4,
        S_STEP   = 3'd5
    } seq_state_e;

    // Flush counter must be able to hold FLUSH_CYC; keep at least one bit so
    // FLUSH_CYC=0 (jumps never bubble) still elaborates.
    localparam int              FC_W    = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC);

    seq_state_e       cur_st;
    seq_state_e       nxt_st;
    logic [DEPTH-1:0] v;            // v[0]=IF/ID ... v[DEPTH-1]=EX/WB
    logic [DEPTH-1:0] v_shift;      // valid chain advanced with an empty slot entering
    logic [FC_W-1:0]  flush_cnt;
    logic [FC_W-1:0]  flush_cnt_nxt;
    logic             stage_adv;
    logic             halt_eff;
    logic             v_empty;
    logic             fetch_ok;

    assign v_shift  = v << 1;
    assign v_empty  = (v == '0);
    assign fetch_ok = (flush_cnt == '0);

`ifdef SEQ_BKPT_EN
    assign halt_eff = halt_req | bkpt_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bkpt_flag <= 1'b0;
        end else if ((cur_st == S_FILL || cur_st == S_RUN) && bkpt_hit) begin
            bkpt_flag <= 1'b1;
        end else if (cur_st == S_HALTED && !halt_req && (step_req || run_req)) begin
            bkpt_flag <= 1'b0;
        end
    end
`else
    assign halt_eff = halt_req;
`endif

    // Next state and all enables. Outputs depend only on registered state so
    // downstream pipeline registers see clean, glitch-free enables.
    always_comb begin
        nxt_st        = cur_st;
        pc_en         = 1'b0;
        stage_adv     = 1'b0;
        ifid_flush    = 1'b0;
        flush_cnt_nxt = '0;

        case (cur_st)
            S_IDLE: begin
                if (run_req) begin
                    nxt_st = S_FILL;
                end
            end

            S_FILL, S_RUN: begin
                pc_en      = 1'b1;
                stage_adv  = 1'b1;
                ifid_flush = !fetch_ok;
                if (halt_eff) begin
                    // Halt wins over a coincident jump; the flush counter is
                    // dropped because DRAIN bubbles every slot anyway.
                    nxt_st = S_DRAIN;
                end else begin
                    if (jump_taken) begin
                        flush_cnt_nxt = FC_LOAD;
                    end else if (!fetch_ok) begin
                        flush_cnt_nxt = flush_cnt - FC_W'(1);
                    end
                    // Move to RUN on the same edge that fills the last stage,
                    // so RUN coincides with the first writeback.
                    if (cur_st == S_FILL && (&(v_shift | DEPTH'(fetch_ok)))) begin
                        nxt_st = S_RUN;
                    end
                end
            end

            S_DRAIN: begin
                stage_adv  = 1'b1;
                ifid_flush = 1'b1;
                if (v_shift == '0) begin
                    nxt_st = S_HALTED;
                end
            end

            S_HALTED: begin
                if (halt_req) begin
                    nxt_st = S_HALTED;
                end else if (step_req) begin
                    nxt_st = S_STEP;
                end else if (run_req) begin
                    nxt_st = S_FILL;
                end
            end

            S_STEP: begin
                // HALTED is only reached with an empty chain, so an empty
                // chain here marks the single fetch cycle of the step.
                stage_adv  = 1'b1;
                pc_en      = v_empty;
                ifid_flush = !v_empty;
                if (!v_empty && v_shift == '0) begin
                    nxt_st = S_HALTED;
                end
            end

            default: begin
                nxt_st = S_IDLE;
            end
        endcase
    end

    assign ifid_en       = stage_adv;
    assign idex_en       = stage_adv;
    assign exwb_en       = stage_adv;
    assign regwrite_gate = v[DEPTH-1] & exwb_en;
    assign busy          = (|v) | pc_en;
    assign state         = cur_st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_st      <= S_IDLE;
            v           <= '0;
            flush_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            cur_st    <= nxt_st;
            flush_cnt <= flush_cnt_nxt;
            if (stage_adv) begin
                v <= v_shift | DEPTH'(pc_en & ~ifid_flush);
            end
            if (regwrite_gate) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - scoreboard bench for pipeline_sequencer

module tb_pipeline_sequencer;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic        jump_taken;
    logic        pc_en, ifid_en, idex_en, exwb_en, ifid_flush, regwrite_gate, busy;
    logic [2:0]  state;
    logic [15:0] retired_cnt;
    logic        pc_en4, ifid_en4, idex_en4, exwb_en4, ifid_flush4, regwrite_gate4, busy4;
    logic [2:0]  state4;
    logic [3:0]  retired_cnt4;
`ifdef SEQ_BKPT_EN
    logic        bkpt_hit;
    logic        bkpt_flag;
    logic        bkpt_flag4;
`endif

    pipeline_sequencer #(.DEPTH(DEPTH), .FLUSH_CYC(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .jump_taken(jump_taken),
`ifdef SEQ_BKPT_EN
        .bkpt_hit(bkpt_hit), .bkpt_flag(bkpt_flag),
`endif
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exwb_en(exwb_en),
        .ifid_flush(ifid_flush), .regwrite_gate(regwrite_gate), .state(state),
        .busy(busy), .retired_cnt(retired_cnt)
    );

    pipeline_sequencer #(.DEPTH(DEPTH), .FLUSH_CYC(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .jump_taken(jump_taken),
`ifdef SEQ_BKPT_EN
        .bkpt_hit(bkpt_hit), .bkpt_flag(bkpt_flag4),
`endif
        .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4), .exwb_en(exwb_en4),
        .ifid_flush(ifid_flush4), .regwrite_gate(regwrite_gate4), .state(state4),
        .busy(busy4), .retired_cnt(retired_cnt4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int sb[$];      // expected retirement cycles

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Retirement monitor: every writeback must match the oldest expected slot.
    always @(negedge clk) begin
        if (reset) begin
            if (sb.size() != 0 && sb[0] < cyc) begin
                chk("sb_missed", cyc, sb[0]);
                void'(sb.pop_front());
            end
            if (regwrite_gate) begin
                if (sb.size() == 0) chk("sb_unexpected", regwrite_gate, 0);
                else                chk("sb_retire_cyc", cyc, sb.pop_front());
            end
        end
    end

    // Start from IDLE/HALTED, fetch n_fetch slots (halt during the last one),
    // optionally jump in fetch slot jump_at. Returns in the first DRAIN cycle.
    task automatic run_segment(input int n_fetch, input int jump_at, input bit first);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        for (int i = 0; i < n_fetch; i++) begin
            chk("fetch_pc_en", pc_en, 1);
            if (i == 0) chk("fill_entry", state, 1);
            if (first && i == DEPTH - 1) begin
                chk("pre_wb_state", state, 1);
                chk("pre_wb_gate", regwrite_gate, 0);
            end
            if (first && i == DEPTH) begin
                chk("first_wb_gate", regwrite_gate, 1);
                chk("first_wb_state", state, 2);
            end
            if (jump_at >= 0 && i == jump_at + 1) chk("flush_on", ifid_flush, 1);
            if (jump_at >= 0 && i == jump_at + 2) chk("flush_off", ifid_flush, 0);
            if (jump_at >= 0 && i == jump_at + 1 + DEPTH) chk("bubble_gate", regwrite_gate, 0);
            if (!(jump_at >= 0 && i == jump_at + 1)) sb.push_back(cyc + DEPTH);
            if (i == jump_at)     jump_taken = 1'b1;
            if (i == n_fetch - 1) halt_req   = 1'b1;
            @(negedge clk);
            jump_taken = 1'b0;
            halt_req   = 1'b0;
        end
        chk("drain_pc_en", pc_en, 0);
        chk("drain_state", state, 3);
        chk("drain_flush", ifid_flush, 1);
    endtask

    task automatic wait_halted(input int budget, input int exp_cnt);
        int k = 0;
        while (state != 3'd4 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("halted", state, 4);
        chk("retired", retired_cnt, exp_cnt);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic do_step(input int exp_cnt);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        chk("step_state", state, 5);
        chk("step_pc_en", pc_en, 1);
        sb.push_back(cyc + DEPTH);
        @(negedge clk);
        chk("step_pc_off", pc_en, 0);
        wait_halted(DEPTH, exp_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        run_req    = 1'b0;
        halt_req   = 1'b0;
        step_req   = 1'b0;
        jump_taken = 1'b0;
`ifdef SEQ_BKPT_EN
        bkpt_hit   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_ens", {ifid_en, idex_en, exwb_en}, 0);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_gate", regwrite_gate, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", retired_cnt, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_hold", state, 0);

        // Fill, run, halt after 20 fetches
        run_segment(20, -1, 1'b1);
        wait_halted(DEPTH, 20);
        chk("cnt4_mod", retired_cnt4, 4);

        // Three single steps
        for (int k = 1; k <= 3; k++) do_step(20 + k);

        // Run with one jump: one of 12 fetched slots is a bubble
        run_segment(12, 5, 1'b0);
        wait_halted(DEPTH, 23 + 11);

        // Narrow counter wrap
        reset = 1'b0;
        @(negedge clk);
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_cnt4", retired_cnt4, 0);
        run_segment(17, -1, 1'b0);
        wait_halted(DEPTH, 17);
        chk("cnt4_wrap", retired_cnt4, 1);

        // Asynchronous reset in the middle of a drain (chain = 110)
        run_segment(6, -1, 1'b0);
        @(negedge clk);
        chk("mid_drain_state", state, 3);
        chk("mid_drain_busy", busy, 1);
        chk("pre_rst_cnt", retired_cnt, 21);
        #2 reset = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_pc_en", pc_en, 0);
        chk("async_ens", {ifid_en, idex_en, exwb_en}, 0);
        chk("async_flush", ifid_flush, 0);
        chk("async_gate", regwrite_gate, 0);
        chk("async_busy", busy, 0);
        chk("async_cnt", retired_cnt, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef SEQ_BKPT_EN
        chk("bk_flag0", bkpt_flag, 0);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(cyc + DEPTH);
            if (i == 5) bkpt_hit = 1'b1;
            @(negedge clk);
            bkpt_hit = 1'b0;
        end
        chk("bk_drain", state, 3);
        chk("bk_flag_set", bkpt_flag, 1);
        wait_halted(DEPTH, 6);
        chk("bk_flag_hold", bkpt_flag, 1);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        chk("bk_flag_clr", bkpt_flag, 0);
        chk("bk_fill", state, 1);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
